// File: rtl/eeg_pea_pair_dispatch_if.sv
`default_nettype none
//==============================================================================
// Module   : eeg_pea_pair_dispatch_if
// Brief    : Activation, weight and PE-side handshake bundle of the pairing stage.
// Revision : 1.0 - initial release
//==============================================================================
interface eeg_pea_pair_dispatch_if #(
    parameter int PE_ROW      = 4,
    parameter int PE_COL      = 4,
    parameter int DATA_ACT_DW = 8,
    parameter int DATA_WEI_DW = 8,
    parameter int ACT_INF_DW  = 12,
    parameter int WEI_INF_DW  = 3,
    parameter int PAIR_DW     = DATA_ACT_DW + DATA_WEI_DW + ACT_INF_DW + WEI_INF_DW + 2
);
    logic [PE_COL-1:0]                    ACT_VLD;
    logic [PE_COL-1:0]                    ACT_RDY;
    logic [PE_COL-1:0]                    ACT_LST;
    logic [PE_COL*DATA_ACT_DW-1:0]        ACT_DAT;
    logic [PE_COL*ACT_INF_DW-1:0]         ACT_INF;
    logic [PE_COL*PE_ROW-1:0]             WEI_VLD;
    logic [PE_COL*PE_ROW-1:0]             WEI_RDY;
    logic [PE_COL*PE_ROW-1:0]             WEI_LST;
    logic [PE_COL*PE_ROW*DATA_WEI_DW-1:0] WEI_DAT;
    logic [PE_COL*PE_ROW*WEI_INF_DW-1:0]  WEI_INF;
    logic [PE_COL*PE_ROW-1:0]             PE_VLD;
    logic [PE_COL*PE_ROW-1:0]             PE_RDY;
    logic [PE_COL*PE_ROW*PAIR_DW-1:0]     PE_DAT;

    modport master (
        output ACT_VLD, ACT_LST, ACT_DAT, ACT_INF,
        output WEI_VLD, WEI_LST, WEI_DAT, WEI_INF,
        output PE_RDY,
        input  ACT_RDY, WEI_RDY, PE_VLD, PE_DAT
    );

    modport slave (
        input  ACT_VLD, ACT_LST, ACT_DAT, ACT_INF,
        input  WEI_VLD, WEI_LST, WEI_DAT, WEI_INF,
        input  PE_RDY,
        output ACT_RDY, WEI_RDY, PE_VLD, PE_DAT
    );
endinterface
`default_nettype wire

// File: rtl/eeg_pea_pair_dispatch.sv
`default_nettype none
//==============================================================================
// Module   : eeg_pea_pair_dispatch
// Brief    : Pairs one activation stream per column with per-row weight streams,
//            reusing each activation for a configurable number of weight beats,
//            and buffers each pair in a per-PE FIFO. Optional per-column beat
//            statistics are built when PEA_PAIR_STAT_EN is defined.
// Revision : 1.0 - initial release
//==============================================================================
module eeg_pea_pair_dispatch #(
    parameter int PE_ROW      = 4,
    parameter int PE_COL      = 4,
    parameter int DATA_ACT_DW = 8,
    parameter int DATA_WEI_DW = 8,
    parameter int ACT_INF_DW  = 12,
    parameter int WEI_INF_DW  = 3,
    parameter int BUF_DEPTH   = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [3:0]        CFG_ACT_REUSE,
    input  wire logic              ERR_CLR,
    output logic                   IS_IDLE,
    output logic [PE_COL-1:0]      ERR,
    output logic [PE_COL*16-1:0]   STAT_BEAT_CNT,
    eeg_pea_pair_dispatch_if.slave bus
);

    localparam int PAIR_DW = DATA_ACT_DW + DATA_WEI_DW + ACT_INF_DW + WEI_INF_DW + 2;
    localparam int NPE     = PE_COL * PE_ROW;
    localparam int PTR_W   = $clog2(BUF_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    logic [PE_COL-1:0]        w_beat;
    logic [PE_COL-1:0]        w_act_rdy;
    logic [PE_COL-1:0]        w_act_lst_st;
    logic [PE_COL-1:0]        w_col_idle;
    logic [NPE-1:0]           w_room;
    logic [NPE-1:0]           w_empty;
    logic [NPE-1:0]           w_wei_rdy;
    logic [NPE-1:0]           w_pe_vld;
    logic [NPE*PAIR_DW-1:0]   w_pe_dat;
    logic                     r_is_idle;

    assign bus.ACT_RDY = w_act_rdy;
    assign bus.WEI_RDY = w_wei_rdy;
    assign bus.PE_VLD  = w_pe_vld;
    assign bus.PE_DAT  = w_pe_dat;
    assign IS_IDLE     = r_is_idle;

    //--------------------------------------------------------------------------
    // Per-column pairing FSM and activation reuse counter
    //--------------------------------------------------------------------------
    for (genvar c = 0; c < PE_COL; c++) begin : g_col
        state_t            r_state;
        state_t            w_nxt;
        logic [3:0]        r_reuse;
        logic [3:0]        r_reuse_cnt;
        logic              r_err;
        logic [PE_ROW-1:0] w_vld_row;
        logic [PE_ROW-1:0] w_lst_row;
        logic              w_all_vld;
        logic              w_lst_all1;
        logic              w_lst_uni;
        logic              w_final;
        logic              w_mis;

        assign w_vld_row  = bus.WEI_VLD[c*PE_ROW +: PE_ROW];
        assign w_lst_row  = bus.WEI_LST[c*PE_ROW +: PE_ROW];
        assign w_all_vld  = &w_vld_row;
        assign w_lst_all1 = &w_lst_row;
        assign w_lst_uni  = w_lst_all1 | ~(|w_lst_row);

        // rst gating keeps an in-flight activation/weight from being consumed
        assign w_beat[c] = !rst && (r_state == ST_RUN) && bus.ACT_VLD[c] && w_all_vld
                           && (&w_room[c*PE_ROW +: PE_ROW]) && w_lst_uni;
        assign w_mis     = (r_state == ST_RUN) && w_all_vld && !w_lst_uni;
        assign w_final   = (r_reuse_cnt == r_reuse) || w_lst_all1;

        assign w_act_rdy[c]    = w_beat[c] && w_final;
        assign w_act_lst_st[c] = w_final && bus.ACT_LST[c];
        assign w_col_idle[c]   = (r_state == ST_IDLE);
        assign ERR[c]          = r_err;

        always_comb begin
            w_nxt = r_state;
            case (r_state)
                ST_IDLE: if (bus.ACT_VLD[c]) w_nxt = ST_RUN;
                ST_RUN: begin
                    // a clear coinciding with a fresh error drops back to IDLE
                    if (w_mis)                                         w_nxt = ERR_CLR ? ST_IDLE : ST_ERR;
                    else if (w_beat[c] && w_final && bus.ACT_LST[c])   w_nxt = ST_IDLE;
                end
                ST_ERR:  if (ERR_CLR) w_nxt = ST_IDLE;
                default: w_nxt = ST_IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state     <= ST_IDLE;
                r_reuse     <= 4'd0;
                r_reuse_cnt <= 4'd0;
                r_err       <= 1'b0;
            end else begin
                r_state <= w_nxt;
                if ((r_state == ST_IDLE) && bus.ACT_VLD[c])
                    r_reuse <= CFG_ACT_REUSE;
                if (ERR_CLR && ((r_state == ST_ERR) || w_mis))
                    r_reuse_cnt <= 4'd0;
                else if (w_beat[c])
                    r_reuse_cnt <= w_final ? 4'd0 : r_reuse_cnt + 4'd1;
                if (ERR_CLR)
                    r_err <= 1'b0;
                else if (w_mis)
                    r_err <= 1'b1;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Per-PE pair FIFO
    //--------------------------------------------------------------------------
    for (genvar p = 0; p < NPE; p++) begin : g_pe
        localparam int C = p / PE_ROW;

        logic [PAIR_DW-1:0] r_mem [BUF_DEPTH];
        logic [PTR_W-1:0]   r_wp;
        logic [PTR_W-1:0]   r_rp;
        logic [CNT_W-1:0]   r_cnt;
        logic               w_push;
        logic               w_pop;
        logic [PAIR_DW-1:0] w_din;

        assign w_push = w_beat[C];
        assign w_pop  = (r_cnt != '0) && bus.PE_RDY[p];
        assign w_din  = {bus.WEI_LST[p], w_act_lst_st[C],
                         bus.WEI_INF[p*WEI_INF_DW +: WEI_INF_DW],
                         bus.ACT_INF[C*ACT_INF_DW +: ACT_INF_DW],
                         bus.WEI_DAT[p*DATA_WEI_DW +: DATA_WEI_DW],
                         bus.ACT_DAT[C*DATA_ACT_DW +: DATA_ACT_DW]};

        // fullness is judged on the current count, so a same-cycle pop never frees a slot
        assign w_room[p]    = (r_cnt < CNT_W'(BUF_DEPTH));
        assign w_empty[p]   = (r_cnt == '0);
        assign w_wei_rdy[p] = w_beat[C];
        assign w_pe_vld[p]  = (r_cnt != '0);
        assign w_pe_dat[p*PAIR_DW +: PAIR_DW] = r_mem[r_rp];

        always_ff @(posedge clk) begin
            if (w_push)
                r_mem[r_wp] <= w_din;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push) r_wp <= r_wp + PTR_W'(1);
                if (w_pop)  r_rp <= r_rp + PTR_W'(1);
                case ({w_push, w_pop})
                    2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                    2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_is_idle <= 1'b1;
        else     r_is_idle <= (&w_col_idle) && (&w_empty);
    end

    //--------------------------------------------------------------------------
    // Optional saturating beat statistics
    //--------------------------------------------------------------------------
`ifdef PEA_PAIR_STAT_EN
    for (genvar c = 0; c < PE_COL; c++) begin : g_stat
        logic [15:0] r_beat_cnt;

        always_ff @(posedge clk) begin
            if (rst)
                r_beat_cnt <= 16'd0;
            else if (w_beat[c] && (r_beat_cnt != 16'hFFFF))
                r_beat_cnt <= r_beat_cnt + 16'd1;
        end

        assign STAT_BEAT_CNT[c*16 +: 16] = r_beat_cnt;
    end
`else
    assign STAT_BEAT_CNT = '0;
`endif

endmodule
`default_nettype wire

// File: doc/eeg_pea_pair_dispatch.md
Name: eeg_pea_pair_dispatch

Overview:
Next-generation operand pairing/dispatch stage in front of the PE array. Each column has one activation stream and one weight stream per PE row. The block pairs them in lockstep across the rows of a column, and reuses each activation for a configurable number of weight beats. Each pair is buffered in a per-PE FIFO of parametrised depth, and weight-last misalignment is detected and flagged per column.

Parameters:
PE_ROW, 4, PE rows per column
PE_COL, 4, columns (independent activation streams)
DATA_ACT_DW, 8, activation data width
DATA_WEI_DW, 8, weight data width
ACT_INF_DW, 12, activation side-info width (address)
WEI_INF_DW, 3, weight side-info width (tap index)
BUF_DEPTH, 4, per-PE FIFO depth; power of two, at least 2
PAIR_DW, derived = DATA_ACT_DW+DATA_WEI_DW+ACT_INF_DW+WEI_INF_DW+2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
CFG_ACT_REUSE  in  4  reuse count minus 1 (0..15 gives 1..16 weight beats per activation)
ERR_CLR  in  1  clears all sticky ERR bits and returns ERR columns to IDLE
IS_IDLE  out  1  all column FSMs IDLE and all FIFOs empty
ERR  out  PE_COL  sticky misalignment flag per column
ACT_VLD/ACT_RDY/ACT_LST  in/out/in  PE_COL  activation handshake per column
ACT_DAT  in  PE_COL*DATA_ACT_DW; ACT_INF  in  PE_COL*ACT_INF_DW
WEI_VLD/WEI_RDY/WEI_LST  in/out/in  PE_COL*PE_ROW  weight handshake per PE
WEI_DAT  in  PE_COL*PE_ROW*DATA_WEI_DW; WEI_INF  in  PE_COL*PE_ROW*WEI_INF_DW
PE_VLD  out  PE_COL*PE_ROW  FIFO head valid
PE_RDY  in  PE_COL*PE_ROW  PE consumes head
PE_DAT  out  PE_COL*PE_ROW*PAIR_DW  packed as {wei_lst, act_lst, wei_inf, act_inf, wei_dat, act_dat}, act_dat at the LSB
STAT_BEAT_CNT  out  PE_COL*16  pairing beat count per column (see Optional Feature)

Behaviour:
- The clock is clk. Reset is rst, synchronous and active-high. All flops update only on the rising edge of clk.
- Reset values: all FSMs IDLE, reuse counters 0, FIFOs empty, ERR=0, PE_VLD=0, STAT_BEAT_CNT=0.
- Reset mid-operation: FIFO contents are discarded, no partial beat is written, and an activation in flight is not consumed.
- Per-column FSM states: IDLE, RUN, ERR.
  - IDLE to RUN when ACT_VLD[c]=1. CFG_ACT_REUSE is latched into a per-column register on this transition and stays stable for the whole segment.
- Beat condition for column c, all terms true in the same cycle:
  - state is RUN
  - ACT_VLD[c]=1
  - every row has WEI_VLD=1
  - every row FIFO has count < BUF_DEPTH
  - WEI_LST is uniform across the rows (all 1 or all 0)
- On a beat:
  - WEI_RDY=1 for all rows of the column, in the same cycle.
  - One entry is written to every row FIFO of the column.
  - The reuse counter increments.
- An activation is final when the reuse counter equals the latched reuse value, or when WEI_LST is all 1s.
  - On a final beat: ACT_RDY[c]=1, the reuse counter returns to 0, and the stored act_lst bit equals ACT_LST[c].
  - On a non-final beat: ACT_RDY[c]=0 and the stored act_lst bit is 0.
  - A final beat with ACT_LST[c]=1 returns the FSM to IDLE; otherwise it stays in RUN.
- ACT_RDY and WEI_RDY are combinational from the valids and FIFO counts. Upstream must not make VLD depend on RDY.
- Misalignment: in RUN, if every row has WEI_VLD=1 and WEI_LST is mixed, go to ERR and set ERR[c]. In ERR, all RDY outputs of the column are 0.
  - ERR_CLR goes to IDLE and clears ERR[c] and the reuse counter. FIFO contents are kept.
  - ERR_CLR and a new error in the same cycle: the clear wins for the current cycle. The error is re-detected only after the FSM has re-entered RUN.
- FIFO behaviour:
  - Registered, with 1-cycle latency: an entry written at edge N shows PE_VLD=1 after edge N.
  - A pop occurs when PE_VLD and PE_RDY are both 1. PE_RDY while empty is ignored.
  - Full is count-based: when count==BUF_DEPTH a write is blocked even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full leaves the count unchanged.
  - Pointers are log2(BUF_DEPTH) bits and wrap naturally.
- IS_IDLE is registered; it reflects the state and FIFOs as of the previous edge.

Optional Feature:
PEA_PAIR_STAT_EN.
- Defined: one 16-bit counter per column increments on every beat and saturates at 0xFFFF. It is cleared by rst only, not by ERR_CLR.
- Undefined: STAT_BEAT_CNT is tied to 0 and no counter flops exist.

Test Plan:
- CFG_ACT_REUSE=2, col0: 1 activation (ACT_LST=1) and 3 weights per row, all valid, PE_RDY=1 -> 3 beats, ACT_RDY high on beat 3 only; each PE receives 3 entries with act_lst=0,0,1; FSM back to IDLE; IS_IDLE=1 two cycles later.
- CFG_ACT_REUSE=15, WEI_LST all 1 on beat 4 -> early final beat: ACT_RDY on beat 4, reuse counter returns to 0, next activation starts pairing.
- BUF_DEPTH=4, PE_RDY[0][2]=0, continuous stream -> exactly 4 beats, then WEI_RDY=0 for the whole of col0; col1 unaffected. Releasing PE_RDY resumes beats one cycle after the first pop.
- Col2 in RUN with WEI_LST=4'b0101, all WEI_VLD=1 -> ERR[2]=1 next cycle and all col2 RDY=0. ERR_CLR pulse -> ERR[2]=0, FSM IDLE, FIFO data intact.
- Assert rst during the 2nd beat of a 3-beat reuse -> all PE_VLD=0 and the FIFOs empty after that edge, ACT_RDY was never asserted, and a fresh segment pairs correctly.
- With PEA_PAIR_STAT_EN: 70000 beats on col3 -> STAT_BEAT_CNT[3]=0xFFFF. Without the macro -> 0.
